dmem_pipelined: RTL

- Parametrised successor to the single-cycle data memory: byte-laned synchronous RAM with a valid/ready request port.
- Read latency is configurable.
- Load data is lane-extracted and sign/zero-extended inside the block.
- Misaligned accesses are detected and recorded in a sticky fault register.
- Sits between the MIPS datapath load/store unit and the data bus; replaces the negedge-read memory so reads become fully posedge-pipelined.

---
 rtl/dmem_pipelined.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_pipelined.sv
// dmem_pipelined: byte-laned synchronous data RAM, valid/ready requests, READ_LAT load pipe.
// Optional `DMEM_STATS_EN adds saturating load/store/fault counters.
module dmem_pipelined #(
    parameter logic [15:0] MEM_ADDR  = 16'h1000,
    parameter int          DEPTH_LOG = 10,
    parameter int          READ_LAT  = 1,
    parameter logic [31:0] INIT_WORD = 32'hADADADAD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        fault,
    output logic [31:0] fault_addr,
    input  logic        fault_clr
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_faults
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int LAST  = READ_LAT - 1;

    logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

    logic                 accept;
    logic                 misaligned;
    logic                 in_window;
    logic                 do_store;
    logic                 do_load;
    logic [DEPTH_LOG-1:0] idx;
    logic [3:0]           be;
    logic [31:0]          wdat;

    logic [READ_LAT-1:0]  vld_q;
    logic [31:0]          word_q [READ_LAT];
    logic [1:0]           lane_q [READ_LAT];
    logic [1:0]           size_q [READ_LAT];
    logic                 sgn_q  [READ_LAT];
    logic                 bad_q  [READ_LAT];

    logic [31:0]          last_word;
    logic [1:0]           last_lane;
    logic [7:0]           byte_v;
    logic [15:0]          half_v;
    logic [31:0]          ext;
    logic [31:0]          hold_q;

    assign req_ready = ~reset;
    assign accept    = req_valid & req_ready;
    assign in_window = (req_addr[31:16] == MEM_ADDR);
    assign idx       = req_addr[DEPTH_LOG+1:2];
    assign do_store  = accept & req_we & ~misaligned & in_window;
    assign do_load   = accept & ~req_we;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = 1'b1;
            2'd3:    misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Narrow stores replicate their data so every enabled lane sees it.
    always_comb begin
        be   = 4'b0000;
        wdat = req_wdata;
        case (req_size)
            2'd0: begin
                be   = 4'b0001 << req_addr[1:0];
                wdat = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be   = req_addr[1] ? 4'b1100 : 4'b0011;
                wdat = {2{req_wdata[15:0]}};
            end
            2'd3:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Array and load-data stages carry no reset; only valid bits do.
    always_ff @(posedge clock) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdat[8*b +: 8];
                end
            end
        end
        if (do_load) begin
            word_q[0] <= mem[idx];
            lane_q[0] <= req_addr[1:0];
            size_q[0] <= req_size;
            sgn_q[0]  <= req_signed;
            bad_q[0]  <= misaligned;
        end
        for (int s = 1; s < READ_LAT; s++) begin
            word_q[s] <= word_q[s-1];
            lane_q[s] <= lane_q[s-1];
            size_q[s] <= size_q[s-1];
            sgn_q[s]  <= sgn_q[s-1];
            bad_q[s]  <= bad_q[s-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= do_load;
            for (int s = 1; s < READ_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    always_comb begin
        last_word = word_q[LAST];
        last_lane = lane_q[LAST];
        byte_v    = last_word[{last_lane, 3'b000} +: 8];
        half_v    = last_word[{last_lane[1], 4'b0000} +: 16];
        ext       = last_word;
        case (size_q[LAST])
            2'd0:    ext = {{24{sgn_q[LAST] & byte_v[7]}}, byte_v};
            2'd1:    ext = {{16{sgn_q[LAST] & half_v[15]}}, half_v};
            default: ext = last_word;
        endcase
        if (bad_q[LAST]) begin
            ext = 32'h0;
        end
    end

    assign resp_valid = vld_q[LAST];
    assign resp_rdata = resp_valid ? ext : hold_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q <= 32'h0;
        end else if (resp_valid) begin
            hold_q <= ext;
        end
    end

    // A fresh fault beats a simultaneous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault      <= 1'b0;
            fault_addr <= 32'h0;
        end else if (accept && misaligned && (!fault || fault_clr)) begin
            fault      <= 1'b1;
            fault_addr <= req_addr;
        end else if (fault_clr) begin
            fault      <= 1'b0;
            fault_addr <= 32'h0;
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_loads  <= 32'h0;
            stat_stores <= 32'h0;
            stat_faults <= 32'h0;
        end else begin
            if (do_load && !misaligned && stat_loads != 32'hFFFF_FFFF) begin
                stat_loads <= stat_loads + 32'd1;
            end
            if (do_store && stat_stores != 32'hFFFF_FFFF) begin
                stat_stores <= stat_stores + 32'd1;
            end
            if (accept && misaligned && stat_faults != 32'hFFFF_FFFF) begin
                stat_faults <= stat_faults + 32'd1;
            end
        end
    end
`endif

endmodule
